ecc_hamming_codec: RTL and testbench

Single-error-correcting Hamming codec. It pairs a parity encoder path with a syndrome decoder/corrector path to protect data words stored in on-chip SRAM. The write side computes check bits, which are stored alongside the data. The read side recomputes the check bits, corrects any single flipped bit in data or check bits, and flags that an error occurred. Each path is an independent one-cycle pipeline on a common clock.

---
 rtl/ecc_hamming_codec.sv | 129 ++++++++++++
 tb/tb_ecc_hamming_codec.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_hamming_codec.sv
// ecc_hamming_codec: single-error-correcting Hamming codec for SRAM words.
// The encoder registers the data with its check bits. The decoder recomputes
// the check bits and builds a syndrome from them. It corrects one flipped
// data bit and flags any non-zero syndrome. The two paths share no state, and
// each is a one-cycle pipeline.
module ecc_hamming_codec #(
  parameter int DATA_W = 26,
  parameter int CODE_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_enc_data,
  input  logic              i_enc_vld,
  output logic [DATA_W-1:0] o_enc_data,
  output logic [CODE_W-1:0] o_enc_code,
  output logic              o_enc_vld,
  input  logic [DATA_W-1:0] i_dec_data,
  input  logic [CODE_W-1:0] i_dec_code,
  input  logic              i_dec_vld,
  output logic [DATA_W-1:0] o_dec_data,
  output logic              o_dec_err,
  output logic              o_dec_vld
);

  // Codeword positions run 1..N_POS. Power-of-two positions hold check bits.
  // All other positions hold data bits in ascending order.
  localparam int N_POS = DATA_W + CODE_W;

  // Even-parity check bits. Check bit k covers every data bit whose codeword
  // position has bit k set.
  function automatic logic [CODE_W-1:0] calc_code(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    int               j;
    code = '0;
    j    = 0;
    for (int p = 1; p <= N_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (j < DATA_W) begin
          for (int k = 0; k < CODE_W; k++) begin
            if (((p >> k) & 1) == 1) begin
              code[k] = code[k] ^ data[j];
            end
          end
        end
        j++;
      end
    end
    return code;
  endfunction

  // Invert the data bit whose position equals the syndrome. A syndrome that
  // names a check-bit position or lies past the end of the codeword leaves
  // the data untouched.
  function automatic logic [DATA_W-1:0] correct(input logic [DATA_W-1:0] data,
                                                input logic [CODE_W-1:0] syn);
    logic [DATA_W-1:0] fixed;
    int                j;
    fixed = data;
    j     = 0;
    for (int p = 1; p <= N_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if ((j < DATA_W) && (int'(syn) == p)) begin
          fixed[j] = ~fixed[j];
        end
        j++;
      end
    end
    return fixed;
  endfunction

  logic [DATA_W-1:0] enc_data_d, enc_data_q;
  logic [CODE_W-1:0] enc_code_d, enc_code_q;
  logic              enc_vld_d, enc_vld_q;
  logic [DATA_W-1:0] dec_data_d, dec_data_q;
  logic              dec_err_d, dec_err_q;
  logic              dec_vld_d, dec_vld_q;
  logic [CODE_W-1:0] syndrome;

  // Encoder next state: load data and check bits on a request, otherwise hold.
  always_comb begin
    enc_data_d = enc_data_q;
    enc_code_d = enc_code_q;
    enc_vld_d  = i_enc_vld;
    if (i_enc_vld) begin
      enc_data_d = i_enc_data;
      enc_code_d = calc_code(i_enc_data);
    end
  end

  // Decoder next state: correct on a request. The error flag is cleared in
  // every cycle with no request.
  always_comb begin
    syndrome   = calc_code(i_dec_data) ^ i_dec_code;
    dec_data_d = dec_data_q;
    dec_err_d  = 1'b0;
    dec_vld_d  = i_dec_vld;
    if (i_dec_vld) begin
      dec_data_d = correct(i_dec_data, syndrome);
      dec_err_d  = (syndrome != '0);
    end
  end

  // Output registers for both paths, with a synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      enc_data_q <= '0;
      enc_code_q <= '0;
      enc_vld_q  <= 1'b0;
      dec_data_q <= '0;
      dec_err_q  <= 1'b0;
      dec_vld_q  <= 1'b0;
    end else begin
      enc_data_q <= enc_data_d;
      enc_code_q <= enc_code_d;
      enc_vld_q  <= enc_vld_d;
      dec_data_q <= dec_data_d;
      dec_err_q  <= dec_err_d;
      dec_vld_q  <= dec_vld_d;
    end
  end

  assign o_enc_data = enc_data_q;
  assign o_enc_code = enc_code_q;
  assign o_enc_vld  = enc_vld_q;
  assign o_dec_data = dec_data_q;
  assign o_dec_err  = dec_err_q;
  assign o_dec_vld  = dec_vld_q;

endmodule

// File: tb/tb_ecc_hamming_codec.sv
// tb_ecc_hamming_codec: directed vectors, a loopback sweep with random
// single-bit flips, and reset/idle behaviour for ecc_hamming_codec.
module tb_ecc_hamming_codec;

  localparam int DW     = 26;
  localparam int CW     = 5;
  localparam int NWORDS = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] enc_data_i;
  logic          enc_vld_i;
  logic [DW-1:0] enc_data_o;
  logic [CW-1:0] enc_code_o;
  logic          enc_vld_o;
  logic [DW-1:0] dec_data_i;
  logic [CW-1:0] dec_code_i;
  logic          dec_vld_i;
  logic [DW-1:0] dec_data_o;
  logic          dec_err_o;
  logic          dec_vld_o;

  int checks = 0;
  int errors = 0;

  // Codeword position of each data bit.
  int pos_tab[DW];

  // Words held in the external store, after any flip has been applied.
  logic [DW-1:0] cap_data[NWORDS];
  logic [CW-1:0] cap_code[NWORDS];
  bit            flip_en[NWORDS];

  // Free-running clock.
  always #5 clk = ~clk;

  ecc_hamming_codec #(.DATA_W(DW), .CODE_W(CW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enc_data (enc_data_i),
    .i_enc_vld  (enc_vld_i),
    .o_enc_data (enc_data_o),
    .o_enc_code (enc_code_o),
    .o_enc_vld  (enc_vld_o),
    .i_dec_data (dec_data_i),
    .i_dec_code (dec_code_i),
    .i_dec_vld  (dec_vld_i),
    .o_dec_data (dec_data_o),
    .o_dec_err  (dec_err_o),
    .o_dec_vld  (dec_vld_o)
  );

  // Reference encoder. A valid codeword has an XOR of zero over the positions
  // of all its set bits, so the check-bit field equals the XOR of the
  // positions of the set data bits.
  function automatic logic [CW-1:0] model_code(input logic [DW-1:0] d);
    int x;
    x = 0;
    for (int j = 0; j < DW; j++) begin
      if (d[j]) x = x ^ pos_tab[j];
    end
    return CW'(x);
  endfunction

  // Compare one observed value with its expected value and count any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return at the falling edge that follows
  // the clock edge.
  task automatic applyStimulus(input logic r, input logic ev, input logic [DW-1:0] ed,
                               input logic dv, input logic [DW-1:0] dd, input logic [CW-1:0] dc);
    rst        = r;
    enc_vld_i  = ev;
    enc_data_i = ed;
    dec_vld_i  = dv;
    dec_data_i = dd;
    dec_code_i = dc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check all six outputs against expected values.
  task automatic checkAll(input string tag, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                          input logic ev, input logic [DW-1:0] dd, input logic de, input logic dv);
    checkOutput($sformatf("%s enc_data", tag), 32'(enc_data_o), 32'(ed));
    checkOutput($sformatf("%s enc_code", tag), 32'(enc_code_o), 32'(ec));
    checkOutput($sformatf("%s enc_vld", tag),  32'(enc_vld_o),  32'(ev));
    checkOutput($sformatf("%s dec_data", tag), 32'(dec_data_o), 32'(dd));
    checkOutput($sformatf("%s dec_err", tag),  32'(dec_err_o),  32'(de));
    checkOutput($sformatf("%s dec_vld", tag),  32'(dec_vld_o),  32'(dv));
  endtask

  // Directed sequence.
  initial begin
    logic [DW-1:0] enc_vec [4];
    logic [CW-1:0] enc_exp [4];
    logic [DW-1:0] word, d;
    logic [CW-1:0] code;
    int            j, p, w;

    enc_vec = '{26'h0000000, 26'h0000001, 26'h0000002, 26'h3FFFFFF};
    enc_exp = '{5'h00, 5'h03, 5'h05, 5'h1F};

    j = 0;
    for (int q = 1; q <= DW + CW; q++) begin
      if ((q & (q - 1)) != 0) begin
        pos_tab[j] = q;
        j++;
      end
    end

    // Reset, with input requests that must be dropped.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 26'h1234567, 1'b1, 26'h0000000, 5'h03);
    checkAll("reset", '0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    checkAll("post-reset idle", '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // Encode vectors, back to back.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, enc_vec[i], 1'b0, '0, '0);
      checkOutput($sformatf("enc vec%0d code", i), 32'(enc_code_o), 32'(enc_exp[i]));
      checkOutput($sformatf("enc vec%0d data", i), 32'(enc_data_o), 32'(enc_vec[i]));
      checkOutput($sformatf("enc vec%0d vld", i),  32'(enc_vld_o),  32'h1);
      checkOutput($sformatf("enc vec%0d dec_vld", i), 32'(dec_vld_o), 32'h0);
    end

    // Data-bit error, check-bit error and clean word.
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 26'h0000000, 5'h03);
    checkOutput("dec d0 flip data", 32'(dec_data_o), 32'h0000001);
    checkOutput("dec d0 flip err",  32'(dec_err_o),  32'h1);
    checkOutput("dec d0 flip vld",  32'(dec_vld_o),  32'h1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 26'h0000001, 5'h13);
    checkOutput("dec c4 flip data", 32'(dec_data_o), 32'h0000001);
    checkOutput("dec c4 flip err",  32'(dec_err_o),  32'h1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 26'h3FFFFFF, 5'h1F);
    checkOutput("dec clean data", 32'(dec_data_o), 32'h3FFFFFF);
    checkOutput("dec clean err",  32'(dec_err_o),  32'h0);

    // Idle cycle: registered data holds, while valid and error drop.
    applyStimulus(1'b0, 1'b0, 26'h0ABCDEF, 1'b0, 26'h0000000, 5'h03);
    checkAll("idle hold", 26'h3FFFFFF, 5'h1F, 1'b0, 26'h3FFFFFF, 1'b0, 1'b0);

    // Loopback sweep. Each encoded word is captured into a one-cycle store,
    // optionally corrupted by one bit, and replayed into the decoder.
    for (int c = 0; c < NWORDS + 2; c++) begin
      w = c - 2;
      applyStimulus(1'b0,
                    (c < NWORDS), (c < NWORDS) ? DW'(c + 1) : '0,
                    (w >= 0), (w >= 0) ? cap_data[w] : '0, (w >= 0) ? cap_code[w] : '0);
      if (c < NWORDS) begin
        word = DW'(c + 1);
        checkOutput($sformatf("loop w%0d enc_vld", c),  32'(enc_vld_o),  32'h1);
        checkOutput($sformatf("loop w%0d enc_code", c), 32'(enc_code_o), 32'(model_code(word)));
        checkOutput($sformatf("loop w%0d enc_data", c), 32'(enc_data_o), 32'(word));
        d          = enc_data_o;
        code       = enc_code_o;
        flip_en[c] = ($urandom_range(0, 1) == 1);
        if (flip_en[c]) begin
          p = int'($urandom_range(1, DW + CW));
          if ((p & (p - 1)) == 0) begin
            for (int k = 0; k < CW; k++) begin
              if (p == (1 << k)) code[k] = ~code[k];
            end
          end else begin
            for (int q = 0; q < DW; q++) begin
              if (pos_tab[q] == p) d[q] = ~d[q];
            end
          end
        end
        cap_data[c] = d;
        cap_code[c] = code;
      end else begin
        checkOutput($sformatf("loop tail%0d enc_vld", c), 32'(enc_vld_o), 32'h0);
      end
      if (w >= 0) begin
        checkOutput($sformatf("loop w%0d dec_vld", w),  32'(dec_vld_o),  32'h1);
        checkOutput($sformatf("loop w%0d dec_data", w), 32'(dec_data_o), 32'(w + 1));
        checkOutput($sformatf("loop w%0d dec_err", w),  32'(dec_err_o),  32'(flip_en[w]));
      end else begin
        checkOutput($sformatf("loop head%0d dec_vld", c), 32'(dec_vld_o), 32'h0);
      end
    end

    // Reset mid-stream: both paths busy when reset arrives.
    applyStimulus(1'b0, 1'b1, 26'h155AA55, 1'b1, 26'h0000000, 5'h05);
    checkOutput("pre-rst dec_data", 32'(dec_data_o), 32'h0000002);
    checkOutput("pre-rst enc_code", 32'(enc_code_o), 32'(model_code(26'h155AA55)));
    applyStimulus(1'b1, 1'b1, 26'h2AA55AA, 1'b1, 26'h0000001, 5'h13);
    checkAll("mid-stream reset", '0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 26'h0FFFFFF, 1'b0, 26'h0000001, 5'h00);
    checkAll("after reset idle", '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // The first word accepted after reset comes out normally.
    applyStimulus(1'b0, 1'b1, 26'h3FFFFFF, 1'b1, 26'h0000001, 5'h03);
    checkAll("first after reset", 26'h3FFFFFF, 5'h1F, 1'b1, 26'h0000001, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
